// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: elastic, multi-stage ShiftRows / InvShiftRows unit.
// The row permutation (forward or inverse, chosen per beat) sits in front of
// stage 0; later stages are plain valid/ready register slices carrying the
// permuted state and a sideband tag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake
//   inv                 per-beat mode (0 = ShiftRows, 1 = InvShiftRows)
//   inp, in_tag         input state (row-major, 32*NB bits) and tag
//   out_valid, out_ready output handshake
//   res, out_tag        permuted state and its tag
//   busy                some stage holds a valid beat
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inv,
    input  logic [32*NB-1:0]  inp,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  res,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be >= 1");
    end

    // Row shift amounts; the 8-column block uses the wider 1/3/4 schedule.
    function automatic int shift_of(input int r);
        int s;
        unique case (r)
            0:       s = 0;
            1:       s = 1;
            2:       s = (NB == 8) ? 3 : 2;
            default: s = (NB == 8) ? 4 : 3;
        endcase
        return s;
    endfunction

    function automatic logic [W-1:0] perm(
        input logic [W-1:0] d,
        input logic         iv
    );
        logic [W-1:0] o;
        int s;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            s = shift_of(r);
            for (int c = 0; c < NB; c++) begin
                src = iv ? (c - s + NB) % NB : (c + s) % NB;
                o[8*(NB*r+c) +: 8] = d[8*(NB*r+src) +: 8];
            end
        end
        return o;
    endfunction

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;
    logic [W-1:0]      data [STAGES];
    logic [TAG_W-1:0]  tag  [STAGES];
    logic [W-1:0]      perm_d;
    logic              full;

    assign perm_d = perm(inp, inv);

    // Stage k may load when any stage from k to the output is empty or the
    // output drains. Written as a flat AND over the tail rather than a
    // ripple so the ready path has no combinational self-reference.
    always_comb begin
        ld   = '0;
        full = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full = full & v[j];
            end
            ld[k] = out_ready | ~full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data[k] <= '0;
                tag[k]  <= '0;
            end
        end else begin
            if (ld[0]) begin
                v[0]    <= in_valid;
                data[0] <= perm_d;
                tag[0]  <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    v[k]    <= v[k-1];
                    data[k] <= data[k-1];
                    tag[k]  <= tag[k-1];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[STAGES-1];
    assign res       = data[STAGES-1];
    assign out_tag   = tag[STAGES-1];
    assign busy      = |v;

endmodule
